// File: rtl/emu_ram_arbiter_pkg.sv
// Shared constants and types for the two-master EmuRam AXI arbiter.
//   NUM_MST / MST_IDX_W : requester count and width of a requester index
//   NUM_CH, CH_AW, CH_AR: address channels arbitrated by the same logic
//   arb_state_e         : per-address-channel grant state
package emu_ram_arbiter_pkg;

  localparam int NUM_MST   = 2;
  localparam int MST_IDX_W = 1;

  localparam int NUM_CH = 2;
  localparam int CH_AW  = 0;
  localparam int CH_AR  = 1;

  // IDLE: free to pick a requester this cycle.
  // HOLD: a request was presented without a handshake; keep it until accepted.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/emu_ram_arb_fifo.sv
// Write-order FIFO: remembers which requester owns each accepted AW so W
// beats are drained in AW order.
//   push/push_idx : enqueue a requester index (AW handshake)
//   pop           : dequeue head (W handshake with wlast)
//   head_idx      : requester owning the oldest outstanding write
//   full/empty    : derived from an occupancy counter
module emu_ram_arb_fifo
  import emu_ram_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [MST_IDX_W-1:0] push_idx,
  input  logic                 pop,
  output logic [MST_IDX_W-1:0] head_idx,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [MST_IDX_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q;
  logic                 do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_idx = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_idx;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/emu_ram_arbiter.sv
// Two-requester AXI4 arbiter in front of the EmuRam model.
//   clk, rst : single clock, synchronous active-high reset
//   s0_axi_* : AXI4 slave port, requester 0
//   s1_axi_* : AXI4 slave port, requester 1
//   m_axi_*  : AXI4 master port to EmuRam; ID is {requester, upstream id}
// AW and AR each get an independent round-robin grant. Accepted AWs record
// their owner in a write-order FIFO which steers W. B/R are routed back by
// the ID MSB. No registers sit in any data path.
module emu_ram_arbiter
  import emu_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_WIDTH     = 4,
  parameter int WORDER_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  // requester 0
  input  logic [ID_WIDTH-1:0]            s0_axi_awid,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic [7:0]                     s0_axi_awlen,
  input  logic [2:0]                     s0_axi_awsize,
  input  logic [1:0]                     s0_axi_awburst,
  input  logic                           s0_axi_awvalid,
  output logic                           s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
  input  logic                           s0_axi_wlast,
  input  logic                           s0_axi_wvalid,
  output logic                           s0_axi_wready,
  output logic [ID_WIDTH-1:0]            s0_axi_bid,
  output logic [1:0]                     s0_axi_bresp,
  output logic                           s0_axi_bvalid,
  input  logic                           s0_axi_bready,
  input  logic [ID_WIDTH-1:0]            s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic [7:0]                     s0_axi_arlen,
  input  logic [2:0]                     s0_axi_arsize,
  input  logic [1:0]                     s0_axi_arburst,
  input  logic                           s0_axi_arvalid,
  output logic                           s0_axi_arready,
  output logic [ID_WIDTH-1:0]            s0_axi_rid,
  output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [1:0]                     s0_axi_rresp,
  output logic                           s0_axi_rlast,
  output logic                           s0_axi_rvalid,
  input  logic                           s0_axi_rready,
  // requester 1
  input  logic [ID_WIDTH-1:0]            s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0]          s1_axi_awaddr,
  input  logic [7:0]                     s1_axi_awlen,
  input  logic [2:0]                     s1_axi_awsize,
  input  logic [1:0]                     s1_axi_awburst,
  input  logic                           s1_axi_awvalid,
  output logic                           s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s1_axi_wstrb,
  input  logic                           s1_axi_wlast,
  input  logic                           s1_axi_wvalid,
  output logic                           s1_axi_wready,
  output logic [ID_WIDTH-1:0]            s1_axi_bid,
  output logic [1:0]                     s1_axi_bresp,
  output logic                           s1_axi_bvalid,
  input  logic                           s1_axi_bready,
  input  logic [ID_WIDTH-1:0]            s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0]          s1_axi_araddr,
  input  logic [7:0]                     s1_axi_arlen,
  input  logic [2:0]                     s1_axi_arsize,
  input  logic [1:0]                     s1_axi_arburst,
  input  logic                           s1_axi_arvalid,
  output logic                           s1_axi_arready,
  output logic [ID_WIDTH-1:0]            s1_axi_rid,
  output logic [DATA_WIDTH-1:0]          s1_axi_rdata,
  output logic [1:0]                     s1_axi_rresp,
  output logic                           s1_axi_rlast,
  output logic                           s1_axi_rvalid,
  input  logic                           s1_axi_rready,
  // downstream to EmuRam
  output logic [ID_WIDTH+MST_IDX_W-1:0]  m_axi_awid,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [7:0]                     m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
  output logic                           m_axi_wlast,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [ID_WIDTH+MST_IDX_W-1:0]  m_axi_bid,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  output logic [ID_WIDTH+MST_IDX_W-1:0]  m_axi_arid,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  output logic [2:0]                     m_axi_arsize,
  output logic [1:0]                     m_axi_arburst,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [ID_WIDTH+MST_IDX_W-1:0]  m_axi_rid,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rlast,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready
);

  localparam int SW = DATA_WIDTH / 8;

  // Requester-indexed views of both slave ports.
  logic [NUM_MST-1:0][ID_WIDTH-1:0]   s_awid, s_arid;
  logic [NUM_MST-1:0][ADDR_WIDTH-1:0] s_awaddr, s_araddr;
  logic [NUM_MST-1:0][7:0]            s_awlen, s_arlen;
  logic [NUM_MST-1:0][2:0]            s_awsize, s_arsize;
  logic [NUM_MST-1:0][1:0]            s_awburst, s_arburst;
  logic [NUM_MST-1:0][DATA_WIDTH-1:0] s_wdata;
  logic [NUM_MST-1:0][SW-1:0]         s_wstrb;
  logic [NUM_MST-1:0]                 s_wlast, s_wvalid, s_bready, s_rready;

  assign s_awid    = {s1_axi_awid,    s0_axi_awid};
  assign s_awaddr  = {s1_axi_awaddr,  s0_axi_awaddr};
  assign s_awlen   = {s1_axi_awlen,   s0_axi_awlen};
  assign s_awsize  = {s1_axi_awsize,  s0_axi_awsize};
  assign s_awburst = {s1_axi_awburst, s0_axi_awburst};
  assign s_arid    = {s1_axi_arid,    s0_axi_arid};
  assign s_araddr  = {s1_axi_araddr,  s0_axi_araddr};
  assign s_arlen   = {s1_axi_arlen,   s0_axi_arlen};
  assign s_arsize  = {s1_axi_arsize,  s0_axi_arsize};
  assign s_arburst = {s1_axi_arburst, s0_axi_arburst};
  assign s_wdata   = {s1_axi_wdata,   s0_axi_wdata};
  assign s_wstrb   = {s1_axi_wstrb,   s0_axi_wstrb};
  assign s_wlast   = {s1_axi_wlast,   s0_axi_wlast};
  assign s_wvalid  = {s1_axi_wvalid,  s0_axi_wvalid};
  assign s_bready  = {s1_axi_bready,  s0_axi_bready};
  assign s_rready  = {s1_axi_rready,  s0_axi_rready};

  // ---------------------------------------------------------------------
  // Address channel arbitration (AW and AR share the same logic)
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0][NUM_MST-1:0]   ch_sv;
  logic [NUM_CH-1:0]                ch_mready, ch_allow, ch_mvalid, ch_hs;
  logic [NUM_CH-1:0][MST_IDX_W-1:0] ch_sel;
  logic [NUM_CH-1:0][NUM_MST-1:0]   ch_sready;
  logic                             fifo_full, fifo_empty;
  logic [MST_IDX_W-1:0]             w_head;

  assign ch_sv[CH_AW]     = {s1_axi_awvalid, s0_axi_awvalid};
  assign ch_sv[CH_AR]     = {s1_axi_arvalid, s0_axi_arvalid};
  assign ch_mready[CH_AW] = m_axi_awready;
  assign ch_mready[CH_AR] = m_axi_arready;
  // A full write-order FIFO blocks new AW grants; the registered flag is
  // used so a same-cycle pop does not open the gate early.
  assign ch_allow[CH_AW]  = ~fifo_full;
  assign ch_allow[CH_AR]  = 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    arb_state_e           st_q, st_d;
    logic [MST_IDX_W-1:0] ptr_q, ptr_d, hold_q, hold_d, sel;
    logic                 grant, mvalid, hs;
    logic [NUM_MST-1:0]   sready;

    always_comb begin
      sel    = ptr_q;
      grant  = 1'b0;
      st_d   = st_q;
      ptr_d  = ptr_q;
      hold_d = hold_q;
      sready = '0;
      if (st_q == ARB_HOLD) begin
        sel   = hold_q;
        grant = 1'b1;
      end else if (ch_allow[c]) begin
        if (ch_sv[c][ptr_q]) begin
          sel   = ptr_q;
          grant = 1'b1;
        end else if (ch_sv[c][~ptr_q]) begin
          sel   = ~ptr_q;
          grant = 1'b1;
        end
      end
      mvalid = grant & ch_sv[c][sel] & ~rst;
      hs     = mvalid & ch_mready[c];
      if (grant && ch_mready[c] && !rst) sready[sel] = 1'b1;
      if (hs) begin
        st_d  = ARB_IDLE;
        ptr_d = ~sel;
      end else if (mvalid) begin
        st_d   = ARB_HOLD;
        hold_d = sel;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= ARB_IDLE;
        ptr_q  <= '0;
        hold_q <= '0;
      end else begin
        st_q   <= st_d;
        ptr_q  <= ptr_d;
        hold_q <= hold_d;
      end
    end

    assign ch_sel[c]    = sel;
    assign ch_mvalid[c] = mvalid;
    assign ch_hs[c]     = hs;
    assign ch_sready[c] = sready;
  end

  assign m_axi_awid     = {ch_sel[CH_AW], s_awid[ch_sel[CH_AW]]};
  assign m_axi_awaddr   = s_awaddr[ch_sel[CH_AW]];
  assign m_axi_awlen    = s_awlen[ch_sel[CH_AW]];
  assign m_axi_awsize   = s_awsize[ch_sel[CH_AW]];
  assign m_axi_awburst  = s_awburst[ch_sel[CH_AW]];
  assign m_axi_awvalid  = ch_mvalid[CH_AW];
  assign s0_axi_awready = ch_sready[CH_AW][0];
  assign s1_axi_awready = ch_sready[CH_AW][1];

  assign m_axi_arid     = {ch_sel[CH_AR], s_arid[ch_sel[CH_AR]]};
  assign m_axi_araddr   = s_araddr[ch_sel[CH_AR]];
  assign m_axi_arlen    = s_arlen[ch_sel[CH_AR]];
  assign m_axi_arsize   = s_arsize[ch_sel[CH_AR]];
  assign m_axi_arburst  = s_arburst[ch_sel[CH_AR]];
  assign m_axi_arvalid  = ch_mvalid[CH_AR];
  assign s0_axi_arready = ch_sready[CH_AR][0];
  assign s1_axi_arready = ch_sready[CH_AR][1];

  // ---------------------------------------------------------------------
  // Write data: follow the owner of the oldest accepted AW
  // ---------------------------------------------------------------------
  logic w_pop;

  emu_ram_arb_fifo #(
    .DEPTH (WORDER_DEPTH)
  ) u_worder (
    .clk      (clk),
    .rst      (rst),
    .push     (ch_hs[CH_AW]),
    .push_idx (ch_sel[CH_AW]),
    .pop      (w_pop),
    .head_idx (w_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign m_axi_wvalid  = ~fifo_empty & s_wvalid[w_head] & ~rst;
  assign m_axi_wdata   = s_wdata[w_head];
  assign m_axi_wstrb   = s_wstrb[w_head];
  assign m_axi_wlast   = s_wlast[w_head];
  assign w_pop         = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  // W offered before its AW simply waits: no owner, no ready.
  assign s0_axi_wready = ~fifo_empty & (w_head == 1'b0) & m_axi_wready & ~rst;
  assign s1_axi_wready = ~fifo_empty & (w_head == 1'b1) & m_axi_wready & ~rst;

  // ---------------------------------------------------------------------
  // Responses: ID MSB names the requester, remaining bits are its own ID
  // ---------------------------------------------------------------------
  logic [MST_IDX_W-1:0] b_sel, r_sel;

  assign b_sel         = m_axi_bid[ID_WIDTH +: MST_IDX_W];
  assign s0_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
  assign s1_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
  assign s0_axi_bresp  = m_axi_bresp;
  assign s1_axi_bresp  = m_axi_bresp;
  assign s0_axi_bvalid = m_axi_bvalid & (b_sel == 1'b0) & ~rst;
  assign s1_axi_bvalid = m_axi_bvalid & (b_sel == 1'b1) & ~rst;
  assign m_axi_bready  = s_bready[b_sel] & ~rst;

  assign r_sel         = m_axi_rid[ID_WIDTH +: MST_IDX_W];
  assign s0_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
  assign s1_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
  assign s0_axi_rdata  = m_axi_rdata;
  assign s1_axi_rdata  = m_axi_rdata;
  assign s0_axi_rresp  = m_axi_rresp;
  assign s1_axi_rresp  = m_axi_rresp;
  assign s0_axi_rlast  = m_axi_rlast;
  assign s1_axi_rlast  = m_axi_rlast;
  assign s0_axi_rvalid = m_axi_rvalid & (r_sel == 1'b0) & ~rst;
  assign s1_axi_rvalid = m_axi_rvalid & (r_sel == 1'b1) & ~rst;
  assign m_axi_rready  = s_rready[r_sel] & ~rst;

endmodule

// File: tb/tb_emu_ram_arbiter.sv
module tb_emu_ram_arbiter;
  localparam int AW = 32, DW = 64, IW = 4, SW = DW / 8, MW = IW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, failures = 0;

  logic [IW-1:0] s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [7:0]    s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0]    s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
  logic [1:0]    s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic          s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic          s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic [DW-1:0] s0_axi_wdata, s1_axi_wdata;
  logic [SW-1:0] s0_axi_wstrb, s1_axi_wstrb;
  logic          s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
  logic          s0_axi_wready, s1_axi_wready;
  logic [IW-1:0] s0_axi_bid, s1_axi_bid, s0_axi_rid, s1_axi_rid;
  logic [1:0]    s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
  logic          s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata;
  logic          s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready;

  logic [MW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  emu_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .WORDER_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // Every handshake-control output the arbiter drives, for the reset checks.
  function automatic logic [14:0] ctrl_vec();
    return {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
            s0_axi_awready, s0_axi_wready, s0_axi_arready,
            s1_axi_awready, s1_axi_wready, s1_axi_arready,
            s0_axi_bvalid, s0_axi_rvalid, s1_axi_bvalid, s1_axi_rvalid};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit later, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_axi_awvalid = 0; s1_axi_awvalid = 0; s0_axi_arvalid = 0; s1_axi_arvalid = 0;
    s0_axi_wvalid = 0;  s1_axi_wvalid = 0;  s0_axi_wlast = 0;   s1_axi_wlast = 0;
    s0_axi_bready = 0;  s1_axi_bready = 0;  s0_axi_rready = 0;  s1_axi_rready = 0;
    s0_axi_awid = 0; s1_axi_awid = 0; s0_axi_arid = 0; s1_axi_arid = 0;
    s0_axi_awaddr = 0; s1_axi_awaddr = 0; s0_axi_araddr = 0; s1_axi_araddr = 0;
    s0_axi_awlen = 0; s1_axi_awlen = 0; s0_axi_arlen = 0; s1_axi_arlen = 0;
    s0_axi_awsize = 3; s1_axi_awsize = 3; s0_axi_arsize = 3; s1_axi_arsize = 3;
    s0_axi_awburst = 1; s1_axi_awburst = 1; s0_axi_arburst = 1; s1_axi_arburst = 1;
    s0_axi_wdata = 0; s1_axi_wdata = 0; s0_axi_wstrb = '1; s1_axi_wstrb = '1;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bid = 0; m_axi_bresp = 0;
    m_axi_rvalid = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    s0_axi_awvalid = 1; s1_axi_arvalid = 1; s0_axi_wvalid = 1; s0_axi_bready = 1;
    m_axi_awready = 1; m_axi_arready = 1; m_axi_wready = 1;
    m_axi_bvalid = 1; m_axi_rvalid = 1; m_axi_rid = 5'h10;
    #1;
    checks++; if (ctrl_vec() !== 15'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_vec()); end
    step(); step();
    rst = 0;
    idle_inputs();
    #1;
    checks++; if (ctrl_vec() !== 15'h0) begin failures++; $display("FAIL post_reset_idle got=%h exp=0", ctrl_vec()); end
  endtask

  task automatic test_ar_rr();
    do_reset();
    s0_axi_arvalid = 1; s0_axi_arid = 4'h3; s0_axi_araddr = 32'hA000_0000;
    s1_axi_arvalid = 1; s1_axi_arid = 4'h3; s1_axi_araddr = 32'hB000_0000;
    m_axi_arready = 1;
    #1;
    checks++; if (m_axi_arid !== 5'h03) begin failures++; $display("FAIL ar_first_id got=%h exp=03", m_axi_arid); end
    checks++; if (m_axi_araddr !== 32'hA000_0000) begin failures++; $display("FAIL ar_first_addr got=%h exp=a0000000", m_axi_araddr); end
    checks++; if ({s1_axi_arready, s0_axi_arready} !== 2'b01) begin failures++; $display("FAIL ar_first_ready got=%b exp=01", {s1_axi_arready, s0_axi_arready}); end
    step();
    s0_axi_arvalid = 0;
    #1;
    checks++; if (m_axi_arid !== 5'h13) begin failures++; $display("FAIL ar_second_id got=%h exp=13", m_axi_arid); end
    checks++; if ({s1_axi_arready, s0_axi_arready} !== 2'b10) begin failures++; $display("FAIL ar_second_ready got=%b exp=10", {s1_axi_arready, s0_axi_arready}); end
    step();
    s1_axi_arvalid = 0;
  endtask

  task automatic test_w_order();
    do_reset();
    m_axi_awready = 1;
    s1_axi_awvalid = 1; s1_axi_awid = 4'h5; s1_axi_awlen = 8'd3;
    #1;
    checks++; if (m_axi_awid !== 5'h15 || m_axi_awlen !== 8'd3) begin failures++; $display("FAIL aw_s1 got=%h/%0d exp=15/3", m_axi_awid, m_axi_awlen); end
    step();
    s1_axi_awvalid = 0; s0_axi_awvalid = 1; s0_axi_awid = 4'h2; s0_axi_awlen = 8'd0;
    #1;
    checks++; if (m_axi_awid !== 5'h02) begin failures++; $display("FAIL aw_s0 got=%h exp=02", m_axi_awid); end
    step();
    s0_axi_awvalid = 0; m_axi_awready = 0;
    m_axi_wready = 1;
    s0_axi_wvalid = 1; s0_axi_wlast = 1; s0_axi_wdata = 64'h5000_0000_0000_0000;
    s1_axi_wvalid = 1;
    for (int k = 0; k < 4; k++) begin
      s1_axi_wdata = 64'h1000 + 64'(k);
      s1_axi_wlast = (k == 3);
      #1;
      checks++; if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== 64'h1000 + 64'(k) || m_axi_wlast !== (k == 3))
        begin failures++; $display("FAIL w_s1_beat%0d got=%b/%h/%b", k, m_axi_wvalid, m_axi_wdata, m_axi_wlast); end
      checks++; if ({s1_axi_wready, s0_axi_wready} !== 2'b10) begin failures++; $display("FAIL w_s1_ready%0d got=%b exp=10", k, {s1_axi_wready, s0_axi_wready}); end
      step();
    end
    s1_axi_wvalid = 0; s1_axi_wlast = 0;
    #1;
    checks++; if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== 64'h5000_0000_0000_0000 || m_axi_wlast !== 1'b1)
      begin failures++; $display("FAIL w_s0_beat got=%b/%h/%b", m_axi_wvalid, m_axi_wdata, m_axi_wlast); end
    checks++; if ({s1_axi_wready, s0_axi_wready} !== 2'b01) begin failures++; $display("FAIL w_s0_ready got=%b exp=01", {s1_axi_wready, s0_axi_wready}); end
    step();
    #1;
    checks++; if (m_axi_wvalid !== 1'b0 || s0_axi_wready !== 1'b0) begin failures++; $display("FAIL w_drained got=%b/%b exp=0/0", m_axi_wvalid, s0_axi_wready); end
    s0_axi_wvalid = 0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_axi_awready = 1;
    s0_axi_awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      s0_axi_awaddr = 32'h100 * i;
      #1;
      checks++; if (m_axi_awvalid !== 1'b1 || s0_axi_awready !== 1'b1) begin failures++; $display("FAIL fill_aw%0d got=%b/%b exp=1/1", i, m_axi_awvalid, s0_axi_awready); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_axi_awvalid !== 1'b0 || s0_axi_awready !== 1'b0) begin failures++; $display("FAIL full_block%0d got=%b/%b exp=0/0", i, m_axi_awvalid, s0_axi_awready); end
      step();
    end
    s0_axi_wvalid = 1; s0_axi_wlast = 1; m_axi_wready = 1;
    #1;
    checks++; if (s0_axi_wready !== 1'b1) begin failures++; $display("FAIL full_pop_wready got=%b exp=1", s0_axi_wready); end
    checks++; if (m_axi_awvalid !== 1'b0) begin failures++; $display("FAIL full_pop_same_cycle got=%b exp=0", m_axi_awvalid); end
    step();
    s0_axi_wvalid = 0; s0_axi_wlast = 0; m_axi_wready = 0;
    #1;
    checks++; if (m_axi_awvalid !== 1'b1 || s0_axi_awready !== 1'b1) begin failures++; $display("FAIL fifth_aw got=%b/%b exp=1/1", m_axi_awvalid, s0_axi_awready); end
    step();
    s0_axi_awvalid = 0;
  endtask

  task automatic test_resp_route();
    do_reset();
    s1_axi_rready = 1; s0_axi_rready = 0;
    m_axi_rvalid = 1; m_axi_rid = 5'h13; m_axi_rdata = 64'hDEAD_BEEF_0000_0001; m_axi_rlast = 0; m_axi_rresp = 2'b00;
    #1;
    checks++; if ({s1_axi_rvalid, s0_axi_rvalid} !== 2'b10 || s1_axi_rid !== 4'h3) begin failures++; $display("FAIL r_to_s1 got=%b/%h exp=10/3", {s1_axi_rvalid, s0_axi_rvalid}, s1_axi_rid); end
    checks++; if (s1_axi_rdata !== 64'hDEAD_BEEF_0000_0001 || s1_axi_rlast !== 1'b0 || m_axi_rready !== 1'b1) begin failures++; $display("FAIL r_s1_payload got=%h/%b/%b", s1_axi_rdata, s1_axi_rlast, m_axi_rready); end
    step();
    m_axi_rid = 5'h03; m_axi_rdata = 64'h0123_4567_89AB_CDEF; m_axi_rlast = 1; m_axi_rresp = 2'b10;
    #1;
    checks++; if ({s1_axi_rvalid, s0_axi_rvalid} !== 2'b01 || s0_axi_rid !== 4'h3) begin failures++; $display("FAIL r_to_s0 got=%b/%h exp=01/3", {s1_axi_rvalid, s0_axi_rvalid}, s0_axi_rid); end
    checks++; if (s0_axi_rlast !== 1'b1 || s0_axi_rresp !== 2'b10 || m_axi_rready !== 1'b0) begin failures++; $display("FAIL r_s0_payload got=%b/%b/%b exp=1/10/0", s0_axi_rlast, s0_axi_rresp, m_axi_rready); end
    step();
    m_axi_rvalid = 0;
    m_axi_bvalid = 1; m_axi_bid = 5'h1A; m_axi_bresp = 2'b11; s0_axi_bready = 1;
    #1;
    checks++; if ({s1_axi_bvalid, s0_axi_bvalid} !== 2'b10 || s1_axi_bid !== 4'hA || s1_axi_bresp !== 2'b11 || m_axi_bready !== 1'b0)
      begin failures++; $display("FAIL b_to_s1 got=%b/%h/%b/%b", {s1_axi_bvalid, s0_axi_bvalid}, s1_axi_bid, s1_axi_bresp, m_axi_bready); end
    step();
    m_axi_bvalid = 0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s0_axi_arvalid = 1; m_axi_arready = 1;
    step();
    s0_axi_arvalid = 0; m_axi_arready = 0;
    s0_axi_awvalid = 1; s0_axi_awlen = 8'd3; m_axi_awready = 1;
    step();
    s0_axi_awvalid = 0; m_axi_awready = 0;
    s0_axi_wvalid = 1; m_axi_wready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (s0_axi_wready !== 1'b1) begin failures++; $display("FAIL burst_beat%0d got=%b exp=1", k, s0_axi_wready); end
      step();
    end
    rst = 1;
    s0_axi_arvalid = 1; s1_axi_arvalid = 1; m_axi_arready = 1;
    s1_axi_awvalid = 1; m_axi_awready = 1;
    #1;
    checks++; if (ctrl_vec() !== 15'h0) begin failures++; $display("FAIL mid_reset_ctrl got=%h exp=0", ctrl_vec()); end
    step();
    rst = 0;
    #1;
    checks++; if (m_axi_wvalid !== 1'b0 || s0_axi_wready !== 1'b0) begin failures++; $display("FAIL mid_reset_fifo_empty got=%b/%b exp=0/0", m_axi_wvalid, s0_axi_wready); end
    checks++; if (m_axi_arvalid !== 1'b1 || m_axi_arid[IW] !== 1'b0 || s0_axi_arready !== 1'b1) begin failures++; $display("FAIL mid_reset_ar_ptr got=%b/%h exp=1/0x", m_axi_arvalid, m_axi_arid); end
    checks++; if (m_axi_awvalid !== 1'b1 || m_axi_awid[IW] !== 1'b1) begin failures++; $display("FAIL mid_reset_new_aw got=%b/%h exp=1/1x", m_axi_awvalid, m_axi_awid); end
    step();
    s0_axi_arvalid = 0; s1_axi_arvalid = 0; m_axi_arready = 0;
    s1_axi_awvalid = 0; m_axi_awready = 0;
    s0_axi_wvalid = 0; s1_axi_wvalid = 1; s1_axi_wlast = 1; s1_axi_wdata = 64'h77;
    #1;
    checks++; if (m_axi_wvalid !== 1'b1 || s1_axi_wready !== 1'b1 || m_axi_wdata !== 64'h77) begin failures++; $display("FAIL mid_reset_new_w got=%b/%b/%h", m_axi_wvalid, s1_axi_wready, m_axi_wdata); end
    step();
    s1_axi_wvalid = 0; s1_axi_wlast = 0;
  endtask

  task automatic test_w_no_aw();
    int bad;
    do_reset();
    bad = 0;
    s0_axi_wvalid = 1; s0_axi_wlast = 1; m_axi_wready = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (s0_axi_wready !== 1'b0 || m_axi_wvalid !== 1'b0) begin failures++; bad++;
        if (bad < 4) $display("FAIL w_no_aw_c%0d got=%b/%b exp=0/0", i, s0_axi_wready, m_axi_wvalid); end
      step();
    end
    s0_axi_wvalid = 0; s0_axi_wlast = 0;
  endtask

  // Reference: a request offered but not accepted stays granted; otherwise
  // the preferred requester wins if asking, else the other one; after each
  // accepted request the preference moves to the requester that lost.
  task automatic test_random_ar();
    logic [1:0]    pend;
    logic [IW-1:0] rid [2];
    logic [AW-1:0] radr [2];
    logic [1:0]    rdy_vec;
    int pref, held, exp;
    do_reset();
    pend = 0; pref = 0; held = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1; rid[m] = IW'($urandom); radr[m] = $urandom;
        end
      s0_axi_arvalid = pend[0]; s0_axi_arid = rid[0]; s0_axi_araddr = radr[0];
      s1_axi_arvalid = pend[1]; s1_axi_arid = rid[1]; s1_axi_araddr = radr[1];
      m_axi_arready = 1'($urandom_range(0, 1));
      if (held >= 0) exp = held;
      else if (pend[pref]) exp = pref;
      else if (pend[1 - pref]) exp = 1 - pref;
      else exp = -1;
      #1;
      rdy_vec = {s1_axi_arready, s0_axi_arready};
      checks++; if (m_axi_arvalid !== (exp >= 0)) begin failures++; $display("FAIL rand_ar_valid c%0d got=%b exp=%0d", cyc, m_axi_arvalid, exp); end
      if (exp >= 0) begin
        checks++; if (m_axi_arid !== {exp[0], rid[exp]} || m_axi_araddr !== radr[exp])
          begin failures++; $display("FAIL rand_ar_payload c%0d got=%h/%h exp=%0d/%h", cyc, m_axi_arid, m_axi_araddr, exp, rid[exp]); end
        checks++; if (rdy_vec !== (m_axi_arready ? (2'b01 << exp) : 2'b00))
          begin failures++; $display("FAIL rand_ar_ready c%0d got=%b exp_master=%0d", cyc, rdy_vec, exp); end
        if (m_axi_arready) begin pend[exp] = 0; pref = 1 - exp; held = -1; end
        else held = exp;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_random_route();
    logic [MW-1:0] id_v;
    logic [DW-1:0] d_v;
    logic          v_v;
    logic [1:0]    rdy;
    do_reset();
    for (int cyc = 0; cyc < 100; cyc++) begin
      id_v = MW'($urandom); d_v = {$urandom, $urandom}; v_v = 1'($urandom);
      rdy = 2'($urandom);
      s0_axi_rready = rdy[0]; s1_axi_rready = rdy[1];
      s0_axi_bready = rdy[1]; s1_axi_bready = rdy[0];
      m_axi_rvalid = v_v; m_axi_rid = id_v; m_axi_rdata = d_v; m_axi_rlast = id_v[0];
      m_axi_bvalid = ~v_v; m_axi_bid = id_v; m_axi_bresp = id_v[1:0];
      #1;
      checks++; if ({s1_axi_rvalid, s0_axi_rvalid} !== (v_v ? (2'b01 << id_v[IW]) : 2'b00) || m_axi_rready !== rdy[id_v[IW]])
        begin failures++; $display("FAIL rand_r_route c%0d got=%b/%b id=%h", cyc, {s1_axi_rvalid, s0_axi_rvalid}, m_axi_rready, id_v); end
      checks++; if ((id_v[IW] ? s1_axi_rid : s0_axi_rid) !== id_v[IW-1:0] || (id_v[IW] ? s1_axi_rdata : s0_axi_rdata) !== d_v
                    || (id_v[IW] ? s1_axi_rlast : s0_axi_rlast) !== id_v[0])
        begin failures++; $display("FAIL rand_r_payload c%0d id=%h", cyc, id_v); end
      checks++; if ({s1_axi_bvalid, s0_axi_bvalid} !== (!v_v ? (2'b01 << id_v[IW]) : 2'b00) || m_axi_bready !== rdy[1 - id_v[IW]]
                    || (id_v[IW] ? s1_axi_bid : s0_axi_bid) !== id_v[IW-1:0])
        begin failures++; $display("FAIL rand_b_route c%0d got=%b/%b id=%h", cyc, {s1_axi_bvalid, s0_axi_bvalid}, m_axi_bready, id_v); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ar_rr();
    test_w_order();
    test_fifo_full();
    test_resp_route();
    test_reset_mid_burst();
    test_w_no_aw();
    test_random_ar();
    test_random_route();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
